tx_buffer: RTL
==============

TX_BUFFER -- requirements
Module: tx_buffer

Interface
REQ-001 Parameter WIDTH, default 8: data byte width.
REQ-002 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Clk  input  1: single clock; all logic on rising edge.
REQ-004 Rst  input  1: reset, synchronous, active-high.
REQ-005 WR  input  1: host write strobe; one byte per cycle while high.
REQ-006 dataIn  input  WIDTH: host byte, sampled when WR=1.
REQ-007 TXRDY  input  1: transmitter shifter idle, ready for a new byte.
REQ-008 LOAD  output  1: one-cycle pulse; transmitter captures dataOut.
REQ-009 dataOut  output  WIDTH: registered byte for the transmitter; valid while LOAD=1.
REQ-010 FULL  output  1: registered; count==DEPTH.
REQ-011 EMPTY  output  1: registered; count==0.
REQ-012 COUNT  output  log2(DEPTH)+1: registered occupancy.
REQ-013 OVF  output  1: sticky overflow flag.

Function
REQ-014 Storage: DEPTH x WIDTH circular buffer; write and read pointers wrap modulo DEPTH.
REQ-015 Write: when WR=1 and FULL=0 at the edge, store dataIn at wptr, wptr+1.
REQ-016 Write while FULL=1: byte dropped, pointers and COUNT unchanged, OVF set to 1; this holds even when a pop occurs in the same cycle.
REQ-017 Pop: occurs on the edge ending the LOAD state; rptr+1.
REQ-018 Simultaneous accepted write and pop: COUNT unchanged; otherwise COUNT +1 on write, -1 on pop.
REQ-019 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_IDLE.
REQ-020 IDLE -> LOAD when TXRDY=1 and EMPTY=0; same edge loads dataOut with mem[rptr].
REQ-021 LOAD lasts exactly one cycle with LOAD=1, then goes to WAIT_BUSY.
REQ-022 WAIT_BUSY -> WAIT_IDLE when TXRDY=0; otherwise hold.
REQ-023 WAIT_IDLE -> IDLE when TXRDY=1; otherwise hold.
REQ-024 LOAD=1 only in the LOAD state; never two LOAD pulses without an intervening TXRDY low-to-high cycle.
REQ-025 dataOut holds its value between loads.
REQ-026 Latency, idle system with TXRDY=1: write accepted at edge N, EMPTY=0 after N, LOAD high in the cycle after edge N+1, pop at edge N+2.
REQ-027 Back-to-back bytes: the next IDLE->LOAD is no earlier than the edge after TXRDY returns high.
REQ-028 The FIFO accepts writes in all FSM states.
REQ-029 OVF is cleared only by Rst.

Reset
REQ-030 When Rst=1 at an edge: wptr=0, rptr=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, LOAD=0, dataOut=0, FSM=IDLE.
REQ-031 Rst overrides WR and TXRDY in the same cycle; memory contents are not reset.
REQ-032 Rst asserted during LOAD/WAIT_*: the in-flight byte is discarded and no LOAD occurs on the edge Rst is sampled or the following cycle.

Structure
REQ-033 FSM state encodings (2-bit) and default WIDTH/DEPTH SHALL live in the shared UART definitions package used by the receive path.
REQ-034 One sub-module, tx_fifo_core, SHALL contain storage, pointers, COUNT, FULL, EMPTY and OVF; tx_buffer instantiates it and holds the FSM and dataOut register.

Verification
REQ-035 Reset with WR=1, TXRDY=1 -> COUNT=0, EMPTY=1, LOAD=0, dataOut=0x00 on the following cycle.
REQ-036 TXRDY=1, write 0xA5 at edge N -> LOAD=1 with dataOut=0xA5 in the cycle after edge N+1; COUNT back to 0 after N+2.
REQ-037 TXRDY=0, write 0x11,0x22,0x33,0x44,0x55 -> FULL=1 after the 4th write, 5th dropped, OVF=1, COUNT=4; then toggle TXRDY -> LOADs deliver 0x11..0x44 in order.
REQ-038 TXRDY held high after LOAD, never dropping -> FSM stays in WAIT_BUSY, no second LOAD although COUNT=3.
REQ-039 Write 6 bytes with pops interleaved so wptr and rptr wrap past 3 -> output order matches input order, COUNT correct every cycle.
REQ-040 Rst asserted in WAIT_IDLE with COUNT=2 -> COUNT=0, EMPTY=1, FSM=IDLE, no LOAD.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data/FIFO sizes and transmit FSM encoding.
package uart_pkg;

    localparam int UART_WIDTH = 8;
    localparam int UART_DEPTH = 4;

    // Transmit-side handshake states.
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_IDLE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_fifo_core.sv
// Circular byte FIFO with registered occupancy flags and a sticky overflow bit.
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
module tx_fifo_core
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = UART_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q, ovf_q;
    logic             wr_ok;

    // A write is accepted only when not already full; a pop in the same
    // cycle does not make room for it.
    assign wr_ok = wr_i && !full_q;

    // Next-state pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_i) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr_ok, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count, flag and overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
            if (wr_i && full_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage array.
    // NOTE: memory has no reset; the pointers define which entries are valid,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/tx_buffer.sv
// Transmit buffer: host-side FIFO feeding a UART shifter through a LOAD
// pulse handshake. A new byte is only offered after TXRDY has gone low
// (shifter busy) and high again (shifter idle) since the previous LOAD.
module tx_buffer
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = UART_DEPTH
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   WR,
    input  logic [WIDTH-1:0]       dataIn,
    input  logic                   TXRDY,
    output logic                   LOAD,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVF
);

    tx_state_e        state_q;
    logic             load_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_empty;
    logic             pop;

    // The byte leaves the FIFO on the edge that ends the LOAD cycle.
    assign pop = (state_q == TX_LOAD);

    tx_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .wr_i    (WR),
        .wdata_i (dataIn),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (COUNT),
        .full_o  (FULL),
        .empty_o (fifo_empty),
        .ovf_o   (OVF)
    );

    // Handshake FSM with registered LOAD pulse and output byte.
    // NOTE: state and outputs share one clocked block and use non-blocking
    // assignments so every register updates from pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= TX_IDLE;
            load_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (TXRDY && !fifo_empty) begin
                        state_q <= TX_LOAD;
                        load_q  <= 1'b1;
                        data_q  <= fifo_head;
                    end
                end
                TX_LOAD: begin
                    state_q <= TX_WAIT_BUSY;
                    load_q  <= 1'b0;
                end
                TX_WAIT_BUSY: begin
                    if (!TXRDY) begin
                        state_q <= TX_WAIT_IDLE;
                    end
                end
                TX_WAIT_IDLE: begin
                    if (TXRDY) begin
                        state_q <= TX_IDLE;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    load_q  <= 1'b0;
                end
            endcase
        end
    end

    assign LOAD    = load_q;
    assign dataOut = data_q;
    assign EMPTY   = fifo_empty;

endmodule
